neuron_mac: RTL and testbench
=============================

# neuron_mac

Signed multiply-accumulate datapath for one neuron. It consumes the group-framing strobes `sel` (first term of a dot-product group) and `en` (last term) produced by the accumulator controller directly upstream. It sums `in_data*in_weight` over the group, adds a bias, rescales, and applies ReLU with saturation. It emits one 8-bit activation per group with a one-cycle valid pulse to the next layer.

## Interface
Parameters:
- `DATA_W`, 8: signed activation input width.
- `WEIGHT_W`, 8: signed weight width.
- `ACC_W`, 20: signed accumulator width. Must be at least `DATA_W+WEIGHT_W`.
- `OUT_W`, 8: unsigned output activation width.
- `FRAC_SHIFT`, 4: arithmetic right shift applied to (acc+bias) before ReLU/clamp.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `sel`, in, 1: this cycle's term starts a new group; the accumulator loads instead of adding.
- `en`, in, 1: this cycle's term ends the group; a result is produced.
- `in_data`, in, `DATA_W`: signed activation.
- `in_weight`, in, `WEIGHT_W`: signed weight.
- `bias`, in, `ACC_W`: signed bias. Sampled at the edge that adds it (stage 3). Must be held stable from `en` until `out_valid`.
- `out_data`, out, `OUT_W`: unsigned activation result.
- `out_valid`, out, 1: one-cycle pulse when `out_data` is new.
- `out_ovf`, out, 1: the accumulator saturated at some point during the group that produced `out_data`. Valid alongside `out_valid`.

## Operation
- Stage 1 (edge k, the edge that samples the inputs): `prod <= in_data*in_weight` (signed, full `DATA_W+WEIGHT_W` width). `sel` and `en` are delayed into `sel_d1` and `en_d1`.
- Stage 2 (edge k+1):
  - If `sel_d1`: `acc <= sext(prod)` and `ovf <= 0`.
  - Else: `acc <= sat(acc + sext(prod))`. The sum is computed at `ACC_W+1` bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. On clamp, `ovf <= 1` (sticky until the next `sel`).
  - `en_d1` is delayed into `en_d2`.
- Stage 3 (edge k+2), when `en_d2` is set:
  - Compute `s = (acc + bias)` at `ACC_W+1` bits, then `>>> FRAC_SHIFT`.
  - `out_data <= 0` if s<0; `2^OUT_W-1` if s exceeds that; otherwise s.
  - `out_valid <= 1` and `out_ovf <= ovf`.
- When `en_d2` is clear: `out_valid <= 0`, and `out_data` and `out_ovf` hold their last values.
- `sel` and `en` in the same cycle form a one-term group: `acc` loads `prod`, then the result is produced.
- `en` without a prior `sel` continues the running sum. This is legal; the group length is unbounded.
- `acc` is not cleared by `en`. Only `sel` or `rst` restarts it.
- Inputs are consumed every cycle. There is no backpressure.

## Timing
- Latency: `out_valid` is registered at edge k+2, where k is the edge that sampled `en=1`. That is 3 cycles from input to visible result.
- Throughput: one term per cycle. Back-to-back groups at the controller cadence (sel, -, -, en) give one `out_valid` every 4 cycles.
- Reset (sync): `prod`, `acc`, `ovf`, all delayed strobes, `out_data`, `out_valid` and `out_ovf` all become 0.
- Reset mid-group or with a strobe in flight: the pipeline is flushed and no `out_valid` is produced for the interrupted group. The first group after reset must begin with `sel`; otherwise it accumulates onto 0.
- `sel` in the cycle right after `en`: the new group loads cleanly and the finished group's result is unaffected. Stage 3 reads `acc` before it is overwritten, because the pipeline alignment guarantees this.

## Test plan
Defaults: 8/8/20/8, shift 4, 4-term groups `sel,-,-,en`.
- x={16,16,16,16}, w={4,4,4,4}, bias=0 -> `out_data`=16, `out_ovf`=0, `out_valid` pulses 3 cycles after the `en` cycle.
- x=10, w=-10 ×4 (sum -400), bias=0 -> `out_data`=0 (ReLU). With bias=+800 instead -> 400>>4 = 25.
- x=127, w=127 ×4 (sum 64516), bias=0 -> 4032 clamps to `out_data`=255, `out_ovf`=0.
- 40-term group of 127×127 (`sel` first, `en` last) -> `acc` saturates at 524287, `out_ovf`=1, `out_data`=255. The next normal group reports `out_ovf`=0.
- Same-cycle `sel`+`en`, x=3, w=5, bias=16 -> 31>>4 gives `out_data`=1. Also `rst` pulsed one cycle after `en` -> no `out_valid`, outputs read 0, and the following group is correct.
- Continuous back-to-back groups with varying random values -> results match a reference model, with `out_valid` spaced exactly 4 cycles apart.

Source files
------------

// File: rtl/neuron_mac.sv
// neuron_mac: signed multiply-accumulate for one neuron.
// Three stages: product, saturating accumulate, then bias, rescale and ReLU clamp.
// sel marks the first term of a group and en marks the last one.
module neuron_mac #(
    parameter int DATA_W     = 8,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 8,
    parameter int FRAC_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    input  logic signed [ACC_W-1:0]    bias,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_valid,
    output logic                       out_ovf
);

    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic signed [PROD_W-1:0] prod;
    logic                     sel_d1;
    logic                     en_d1;
    logic                     en_d2;
    logic signed [ACC_W-1:0]  acc;
    logic                     ovf;

    logic signed [ACC_W:0]    acc_sum;
    logic                     acc_clip;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W:0]    bias_sum;
    logic signed [ACC_W:0]    scaled;
    logic [OUT_W-1:0]         act;

    // Stage 1: register the product and delay the framing strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            sel_d1 <= 1'b0;
            en_d1  <= 1'b0;
        end else begin
            prod   <= PROD_W'(in_data) * PROD_W'(in_weight);
            sel_d1 <= sel;
            en_d1  <= en;
        end
    end

    // Saturating add, one guard bit wide; sign and guard bits disagree only on overflow.
    always_comb begin
        acc_sum  = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod);
        acc_clip = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        acc_next = acc_sum[ACC_W-1:0];
        if (acc_clip) begin
            acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                      : {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    // Stage 2: load on the first term of a group, otherwise accumulate with a sticky clip flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            en_d2 <= 1'b0;
        end else begin
            en_d2 <= en_d1;
            if (sel_d1) begin
                acc <= ACC_W'(prod);
                ovf <= 1'b0;
            end else begin
                acc <= acc_next;
                if (acc_clip) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Bias, arithmetic rescale, then ReLU with clamp to the unsigned output range.
    always_comb begin
        bias_sum = (ACC_W + 1)'(acc) + (ACC_W + 1)'(bias);
        scaled   = bias_sum >>> FRAC_SHIFT;
        act      = scaled[OUT_W-1:0];
        if (scaled[ACC_W]) begin
            act = '0;
        end else if (|scaled[ACC_W-1:OUT_W]) begin
            act = '1;
        end
    end

    // Stage 3: publish the result; acc still holds this group's sum even if sel already arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= en_d2;
            if (en_d2) begin
                out_data <= act;
                out_ovf  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed groups, reset cases and a short
// back-to-back run against a small reference model.
module tb_neuron_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               sel;
    logic               en;
    logic signed [7:0]  in_data;
    logic signed [7:0]  in_weight;
    logic signed [19:0] bias;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ovf;

    neuron_mac dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .en        (en),
        .in_data   (in_data),
        .in_weight (in_weight),
        .bias      (bias),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int data;
        int ovf;
        int gap;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_vcyc = -1;
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Count rising edges so expectations can be pinned to an exact cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare outputs against the expectation queue on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            check("valid", 32'(out_valid), 1);
            check("data", 32'(out_data), 32'(q[0].data));
            check("ovf", 32'(out_ovf), 32'(q[0].ovf));
            if (q[0].gap > 0) check("gap", 32'(cyc - last_vcyc), 32'(q[0].gap));
            last_vcyc = cyc;
            void'(q.pop_front());
        end else if (out_valid) begin
            check("spurious_valid", 32'(out_valid), 0);
        end
    end

    // One input cycle; bias changes only on the last term so it stays stable to the output edge.
    task automatic term(input logic s, input logic e, input int x, input int w, input int b,
                        input logic push, input int ed, input int eo, input int gap);
        sel       = s;
        en        = e;
        in_data   = x[7:0];
        in_weight = w[7:0];
        if (e) bias = b[19:0];
        if (e && push) q.push_back('{cyc + 3, ed, eo, gap});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) term(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic group(input int n, input int x, input int w, input int b, input logic first_sel,
                         input logic push, input int ed, input int eo);
        for (int i = 0; i < n; i++)
            term(first_sel && (i == 0), i == n - 1, x, w, b, push, ed, eo, 0);
    endtask

    int acc_m, p, s, xr, wr, br, exp_d, exp_o;

    initial begin
        rst = 1'b1; sel = 1'b0; en = 1'b0; in_data = '0; in_weight = '0; bias = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 32'(out_data), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ovf", 32'(out_ovf), 0);
        rst = 1'b0;
        idle(2);

        group(4, 16, 4, 0, 1'b1, 1'b1, 16, 0);        // 256>>4
        group(4, 10, -10, 0, 1'b1, 1'b1, 0, 0);       // -400 -> ReLU
        group(4, 10, -10, 800, 1'b1, 1'b1, 25, 0);    // 400>>4
        group(4, 127, 127, 0, 1'b1, 1'b1, 255, 0);    // 4032 clamps
        group(40, 127, 127, 0, 1'b1, 1'b1, 255, 1);   // acc saturates high
        group(4, 16, 4, 0, 1'b1, 1'b1, 16, 0);        // ovf cleared by sel
        group(4, 16, 4, 0, 1'b0, 1'b1, 32, 0);        // no sel: continues to 512
        group(40, -128, 127, 0, 1'b1, 1'b1, 0, 1);    // acc saturates low
        term(1'b1, 1'b1, 3, 5, 16, 1'b1, 1, 0, 0);    // one-term group: 31>>4
        idle(4);

        // Reset one cycle after en drops the in-flight result.
        group(4, 16, 4, 0, 1'b1, 1'b0, 0, 0);
        rst = 1'b1; sel = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("flush_data", 32'(out_data), 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_ovf", 32'(out_ovf), 0);
        idle(4);
        group(4, 16, 4, 0, 1'b1, 1'b1, 16, 0);

        // Back-to-back random groups against the model; valids exactly 4 cycles apart.
        for (int g = 0; g < 12; g++) begin
            br = int'($urandom_range(0, 4000)) - 2000;
            acc_m = 0;
            for (int i = 0; i < 4; i++) begin
                xr = int'($urandom_range(0, 255)) - 128;
                wr = int'($urandom_range(0, 255)) - 128;
                p = xr * wr;
                acc_m = (i == 0) ? p : acc_m + p;
                if (i == 3) begin
                    s = (acc_m + br) >>> 4;
                    exp_d = (s < 0) ? 0 : (s > 255) ? 255 : s;
                    exp_o = 0;
                end
                term(i == 0, i == 3, xr, wr, br, 1'b1, exp_d, exp_o, (g == 0) ? 0 : 4);
            end
        end

        idle(6);
        check("drain", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
